friscv_rv32i_dmem_axil_bridge: RTL and testbench
================================================

Name: friscv_rv32i_dmem_axil_bridge

Overview:
Sits directly downstream of the RV32I processing stage's data-memory port (mem_en/mem_wr/mem_addr/mem_wdata/mem_strb/mem_rdata/mem_ready). It converts each single-beat load/store request into an AXI4-lite master transaction and returns completion, read data and error status to the load/store unit. It handles one outstanding transaction at a time, with registered AXI outputs.

Parameters:
ADDRW, 16, data memory address width (mem_addr and AXI addresses)
XLEN, 32, data width; strobe width is XLEN/8

Ports:
aclk  in  1  clock; all logic rising-edge
aresetn  in  1  asynchronous active-low reset
srst  in  1  synchronous active-high clear, same effect as aresetn
mem_en  in  1  request valid; held with fields stable until mem_ready
mem_wr  in  1  1=store, 0=load
mem_addr  in  ADDRW  byte address
mem_wdata  in  XLEN  store data
mem_strb  in  XLEN/8  store byte enables
mem_rdata  out  XLEN  load data; valid only while mem_ready=1 for a load
mem_ready  out  1  one-cycle completion pulse
mem_err  out  1  qualified by mem_ready; 1 when AXI resp != OKAY
awvalid/awready/awaddr[ADDRW]/awprot[3]  out/in/out/out  AXI4-lite write address
wvalid/wready/wdata[XLEN]/wstrb[XLEN/8]  out/in/out/out  AXI4-lite write data
bvalid/bready/bresp[2]  in/out/in  AXI4-lite write response
arvalid/arready/araddr[ADDRW]/arprot[3]  out/in/out/out  AXI4-lite read address
rvalid/rready/rdata[XLEN]/rresp[2]  in/out/in/in  AXI4-lite read data

Behaviour:
- Reset (aresetn low async, or srst high at clock edge): state IDLE; every output 0, including all valid/ready signals, addresses, data, mem_rdata and mem_err.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE with mem_en=1:
  - Register addr, wdata and strb.
  - For mem_wr=1: raise awvalid and wvalid next cycle and go to WR_REQ.
  - For mem_wr=0: raise arvalid and go to RD_REQ.
- WR_REQ:
  - awvalid drops in the cycle after its own awvalid&awready handshake; wvalid drops independently after its own handshake. Either order, or both in the same cycle, is legal.
  - When both handshakes are done, go to WR_RESP with bready=1.
- WR_RESP: on bvalid&bready, drop bready, latch mem_err=(bresp!=0), go to DONE.
- RD_REQ: on arvalid&arready, drop arvalid, go to RD_RESP with rready=1.
- RD_RESP: on rvalid&rready, latch rdata into mem_rdata and mem_err=(rresp!=0), drop rready, go to DONE.
- DONE:
  - mem_ready=1 for exactly this cycle, then go to IDLE.
  - mem_en is ignored in DONE, because the completed request is still presented.
  - A new request is sampled in IDLE at the earliest one cycle later.
- Latency: with AXI slave ready/valid at 1 and zero wait, a load sampled at cycle 0 gives arvalid at cycle 1, R handshake at cycle 2 and mem_ready at cycle 3. A store has the same latency: AW/W at 1, B at 2, mem_ready at 3. Minimum request spacing is 4 cycles.
- AXI valids are never withdrawn before their handshake; addr/data stay stable while valid.
- awprot and arprot are fixed at 3'b000.
- awaddr/araddr equal the captured mem_addr. No alignment checks; the upstream unit guarantees alignment.
- mem_rdata holds its last value outside mem_ready; mem_err is 0 outside mem_ready.
- For stores, mem_rdata is unchanged.
- Unexpected bvalid or rvalid outside the WR_RESP/RD_RESP states is ignored, because bready/rready are 0 there.
- Reset mid-transaction: aborts immediately and returns to IDLE with outputs at 0. Re-issuing the request is the requester's responsibility.

Decomposition:
- Shared package (friscv_h): AXI resp encodings (OKAY=2'b00, EXOKAY, SLVERR, DECERR) and the bridge FSM state enum typedef.
- No sub-module. The single FSM plus capture registers is under 250 lines.

Test Plan:
- Load, zero-wait slave: mem_en=1, mem_wr=0, mem_addr=0x0040, rdata=0xDEADBEEF. Required: araddr=0x0040 at cycle 1, mem_ready pulse at cycle 3 with mem_rdata=0xDEADBEEF and mem_err=0.
- Store with AW ready 3 cycles before W: addr=0x0100, wdata=0x12345678, strb=4'b0011. Required: awvalid drops after its handshake, wvalid stays high until wready, bready only after both. Single mem_ready pulse; wstrb=4'b0011 observed.
- Error response: load answered with rresp=2'b10. Required: mem_ready=1 with mem_err=1. A following load with OKAY gives mem_err=0.
- Back-to-back: mem_en held high across the DONE cycle, then a new store is presented. Required: exactly one transaction per request; the DONE-cycle mem_en does not create a duplicate arvalid/awvalid.
- Backpressure: arready=0 for 10 cycles. Required: arvalid and araddr stay stable for all 10 cycles, and mem_ready stays 0 until the R handshake.
- Reset mid-op: assert aresetn=0 asynchronously while in WR_RESP. Required: all outputs are 0 immediately with no clock. After release, a load completes normally in 3 cycles. Repeat the same check using srst.

Source files
------------

// File: rtl/friscv_rv32i_dmem_axil_bridge_pkg.sv
// Shared definitions for the RV32I data-memory to AXI4-lite bridge:
// AXI response encodings and the bridge FSM state type.
package friscv_h;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } bridge_state_t;

endpackage

// File: rtl/friscv_rv32i_dmem_axil_bridge.sv
// Converts single-beat load/store requests from the RV32I LSU into AXI4-lite
// master transactions, one outstanding at a time, with every output registered.
module friscv_rv32i_dmem_axil_bridge
  import friscv_h::*;
#(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                srst,
  input  logic                mem_en,
  input  logic                mem_wr,
  input  logic [ADDRW-1:0]    mem_addr,
  input  logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN/8-1:0]   mem_strb,
  output logic [XLEN-1:0]     mem_rdata,
  output logic                mem_ready,
  output logic                mem_err,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDRW-1:0]    awaddr,
  output logic [2:0]          awprot,
  output logic                wvalid,
  input  logic                wready,
  output logic [XLEN-1:0]     wdata,
  output logic [XLEN/8-1:0]   wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDRW-1:0]    araddr,
  output logic [2:0]          arprot,
  input  logic                rvalid,
  output logic                rready,
  input  logic [XLEN-1:0]     rdata,
  input  logic [1:0]          rresp
);

  bridge_state_t            state_q,     state_d;
  logic                     awvalid_q,   awvalid_d;
  logic                     wvalid_q,    wvalid_d;
  logic                     bready_q,    bready_d;
  logic                     arvalid_q,   arvalid_d;
  logic                     rready_q,    rready_d;
  logic                     mem_ready_q, mem_ready_d;
  logic                     mem_err_q,   mem_err_d;
  logic [XLEN-1:0]          mem_rdata_q, mem_rdata_d;
  logic [ADDRW-1:0]         addr_q,      addr_d;
  logic [XLEN-1:0]          wdata_q,     wdata_d;
  logic [XLEN/8-1:0]        strb_q,      strb_d;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    mem_ready_d = 1'b0;
    mem_err_d   = 1'b0;
    mem_rdata_d = mem_rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_en) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          strb_d  = mem_strb;
          if (mem_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        // AW and W channels retire independently; move on once both have.
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          mem_err_d   = (bresp != RESP_OKAY);
          mem_ready_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (rvalid) begin
          rready_d    = 1'b0;
          mem_rdata_d = rdata;
          mem_err_d   = (rresp != RESP_OKAY);
          mem_ready_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      // The finished request is still on mem_en here, so it must not be re-sampled.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
    end else if (srst) begin
      state_q     <= ST_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
      mem_rdata_q <= mem_rdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
    end
  end

  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign mem_err   = mem_err_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign awprot    = 3'b000;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = strb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign arprot    = 3'b000;
  assign rready    = rready_q;

endmodule

// File: tb/tb_friscv_rv32i_dmem_axil_bridge.sv
// Directed bench for the dmem AXI4-lite bridge: loads, stores, error responses,
// back-to-back requests, backpressure and both reset flavours.
module tb_friscv_rv32i_dmem_axil_bridge;

  localparam int ADDRW = 16;
  localparam int XLEN  = 32;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              srst;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDRW-1:0]  mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_strb;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;
  logic              mem_err;
  logic              awvalid, awready;
  logic [ADDRW-1:0]  awaddr;
  logic [2:0]        awprot;
  logic              wvalid, wready;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [ADDRW-1:0]  araddr;
  logic [2:0]        arprot;
  logic              rvalid, rready;
  logic [XLEN-1:0]   rdata;
  logic [1:0]        rresp;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int aw_hs_cnt = 0;
  int ar_hs_cnt = 0;
  int ready_base, aw_base, ar_base;

  friscv_rv32i_dmem_axil_bridge #(.ADDRW(ADDRW), .XLEN(XLEN)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_err(mem_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 aclk = ~aclk;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge aclk) begin
    if (mem_ready)         ready_cnt++;
    if (awvalid & awready) aw_hs_cnt++;
    if (arvalid & arready) ar_hs_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valids"}, {awvalid, wvalid, bready, arvalid, rready, mem_ready, mem_err}, 0);
    check({tag, ".awaddr"}, awaddr, 0);
    check({tag, ".araddr"}, araddr, 0);
    check({tag, ".wdata"},  wdata, 0);
    check({tag, ".wstrb"},  wstrb, 0);
    check({tag, ".rdata"},  mem_rdata, 0);
    check({tag, ".prot"},   {awprot, arprot}, 0);
  endtask

  task automatic idle_slave();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
  endtask

  task automatic req(input logic wr, input logic [ADDRW-1:0] a,
                     input logic [XLEN-1:0] d, input logic [XLEN/8-1:0] s);
    mem_en = 1'b1; mem_wr = wr; mem_addr = a; mem_wdata = d; mem_strb = s;
  endtask

  // Zero-wait load: presented now, mem_ready expected three cycles later.
  task automatic zero_wait_load(input string tag, input logic [ADDRW-1:0] a,
                                input logic [XLEN-1:0] d, input logic [1:0] resp);
    req(1'b0, a, '0, '0);
    arready = 1'b1; rvalid = 1'b1; rdata = d; rresp = resp;
    step();
    check({tag, ".c1_arvalid"}, arvalid, 1);
    check({tag, ".c1_araddr"},  araddr, a);
    step();
    check({tag, ".c2_rready"},  {arvalid, rready, mem_ready}, 3'b010);
    step();
    check({tag, ".c3_ready"},   mem_ready, 1);
    check({tag, ".c3_rdata"},   mem_rdata, d);
    check({tag, ".c3_err"},     mem_err, (resp != 2'b00));
    mem_en = 1'b0;
    idle_slave();
    step();
    check({tag, ".c4_idle"},    {mem_ready, mem_err, arvalid}, 0);
    check({tag, ".c4_hold"},    mem_rdata, d);
  endtask

  initial begin
    aresetn = 1'b0; srst = 1'b0;
    mem_en = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_strb = '0;
    idle_slave();
    #12;
    check_all_zero("reset");
    aresetn = 1'b1;
    step();
    check_all_zero("post_reset");

    // Load, zero-wait slave.
    zero_wait_load("load0", 16'h0040, 32'hDEADBEEF, 2'b00);

    // Store with AW accepted three cycles ahead of W.
    ready_base = ready_cnt;
    req(1'b1, 16'h0100, 32'h12345678, 4'b0011);
    awready = 1'b1;
    step();
    check("st.c1_valids", {awvalid, wvalid}, 2'b11);
    check("st.c1_awaddr", awaddr, 16'h0100);
    check("st.c1_wdata",  wdata, 32'h12345678);
    check("st.c1_wstrb",  wstrb, 4'b0011);
    step();
    check("st.c2_aw_drop", {awvalid, wvalid, bready}, 3'b010);
    step();
    check("st.c3_w_hold",  {awvalid, wvalid, bready}, 3'b010);
    check("st.c3_wstrb",   wstrb, 4'b0011);
    wready = 1'b1;
    step();
    check("st.c4_bready",  {awvalid, wvalid, bready, mem_ready}, 4'b0010);
    bvalid = 1'b1; bresp = 2'b00;
    step();
    check("st.c5_ready",   {mem_ready, mem_err, bready}, 3'b100);
    check("st.c5_rdata",   mem_rdata, 32'hDEADBEEF);
    mem_en = 1'b0;
    idle_slave();
    step();
    check("st.c6_idle",    mem_ready, 0);
    check("st.one_pulse",  ready_cnt - ready_base, 1);

    // Error response, then a clean load clears mem_err.
    zero_wait_load("err", 16'h0044, 32'hCAFEF00D, 2'b10);
    zero_wait_load("ok_after_err", 16'h0048, 32'h0BADF00D, 2'b00);

    // Back-to-back: mem_en still high through DONE, then a store follows.
    ready_base = ready_cnt; aw_base = aw_hs_cnt; ar_base = ar_hs_cnt;
    req(1'b0, 16'h0080, '0, '0);
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hA5A5_5A5A;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    step(); step(); step();
    check("b2b.ld_ready",  mem_ready, 1);
    check("b2b.ld_rdata",  mem_rdata, 32'hA5A5_5A5A);
    step();
    check("b2b.no_dup_ar", {arvalid, awvalid, mem_ready}, 0);
    req(1'b1, 16'h0084, 32'h0F0F_0F0F, 4'b1111);
    step();
    check("b2b.st_aw",     {awvalid, wvalid, arvalid}, 3'b110);
    check("b2b.st_awaddr", awaddr, 16'h0084);
    step(); step();
    check("b2b.st_ready",  mem_ready, 1);
    mem_en = 1'b0;
    idle_slave();
    step(); step();
    check("b2b.ready_cnt", ready_cnt - ready_base, 2);
    check("b2b.aw_cnt",    aw_hs_cnt - aw_base, 1);
    check("b2b.ar_cnt",    ar_hs_cnt - ar_base, 1);

    // Backpressure: arready low for ten cycles.
    req(1'b0, 16'h0200, '0, '0);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("bp.arvalid_%0d", i), {arvalid, mem_ready, rready}, 3'b100);
      check($sformatf("bp.araddr_%0d", i),  araddr, 16'h0200);
    end
    arready = 1'b1;
    step();
    check("bp.rready", {arvalid, rready, mem_ready}, 3'b010);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1357_9BDF;
    step();
    check("bp.ready",  mem_ready, 1);
    check("bp.rdata",  mem_rdata, 32'h1357_9BDF);
    mem_en = 1'b0;
    idle_slave();
    step();

    // Asynchronous reset while waiting for B.
    req(1'b1, 16'h0300, 32'hFFFF_0000, 4'b1100);
    awready = 1'b1; wready = 1'b1;
    step(); step();
    check("arst.in_wr_resp", bready, 1);
    #2 aresetn = 1'b0;
    #1;
    check_all_zero("arst");
    mem_en = 1'b0;
    idle_slave();
    #3 aresetn = 1'b1;
    step();
    zero_wait_load("arst_load", 16'h0010, 32'h2468_ACE0, 2'b00);

    // Synchronous clear while waiting for B.
    req(1'b1, 16'h0304, 32'h0000_FFFF, 4'b0011);
    awready = 1'b1; wready = 1'b1;
    step(); step();
    check("srst.in_wr_resp", bready, 1);
    srst = 1'b1;
    mem_en = 1'b0;
    idle_slave();
    step();
    check_all_zero("srst");
    srst = 1'b0;
    zero_wait_load("srst_load", 16'h0020, 32'h8642_0ECA, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
